// File: rtl/weight_loader_quad_if.sv
// weight_loader_quad_if: request, buffer-read and chain-load bundle of the weight loader
// master: requester/buffer side (drives start, base_addr, bank_sel, commit, buf_rd_data)
// slave : loader side (drives buf_rd_en/addr, prepare/set_weight, load lanes, busy, weights_ready, done)
interface weight_loader_quad_if #(parameter int ADDR_W = 15);
  logic start, bank_sel, commit;
  logic [ADDR_W-1:0] base_addr;
  logic buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [31:0] buf_rd_data;
  logic prepare_weight, set_weight, busy, weights_ready, done;
  logic [7:0] load_weight_data_a_0, load_weight_data_b_0, load_weight_data_c_0, load_weight_data_d_0;
  logic [7:0] load_weight_data_a_1, load_weight_data_b_1, load_weight_data_c_1, load_weight_data_d_1;
  modport master(
    output start, base_addr, bank_sel, commit, buf_rd_data,
    input buf_rd_en, buf_rd_addr, prepare_weight, set_weight, busy, weights_ready, done,
    input load_weight_data_a_0, load_weight_data_b_0, load_weight_data_c_0, load_weight_data_d_0,
    input load_weight_data_a_1, load_weight_data_b_1, load_weight_data_c_1, load_weight_data_d_1
  );
  modport slave(
    input start, base_addr, bank_sel, commit, buf_rd_data,
    output buf_rd_en, buf_rd_addr, prepare_weight, set_weight, busy, weights_ready, done,
    output load_weight_data_a_0, load_weight_data_b_0, load_weight_data_c_0, load_weight_data_d_0,
    output load_weight_data_a_1, load_weight_data_b_1, load_weight_data_c_1, load_weight_data_d_1
  );
endinterface

// File: rtl/weight_loader_quad.sv
// weight_loader_quad: reads CHAIN_DEPTH weight words and shifts them into a mac_quad chain, then commits them
// Ports: clk, rst_n (sync, active low), bus (weight_loader_quad_if.slave: start/base_addr/bank_sel/commit in,
//   buffer read port, prepare_weight/set_weight, bank 0/1 load lanes, busy/weights_ready/done).
// Option: WEIGHT_LOADER_AUTO_COMMIT_EN makes READY last one cycle and commit automatically.
module weight_loader_quad #(
  parameter int BUFFER_ADDR_WIDTH = 15,
  parameter int CHAIN_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  weight_loader_quad_if.slave bus
);
  localparam int CW = CHAIN_DEPTH > 1 ? $clog2(CHAIN_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, READY, COMMIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [BUFFER_ADDR_WIDTH-1:0] base;
  logic bank, valid, last;
  assign last = cnt == CW'(CHAIN_DEPTH - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      bank <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == LOAD && !last) ? cnt + CW'(1) : '0;
      // buffer has one cycle of latency, so a word is presented the cycle after its read
      valid <= state == LOAD;
      if (state == IDLE && bus.start) begin
        base <= bus.base_addr;
        bank <= bus.bank_sel;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.start ? LOAD : IDLE;
      LOAD: state_nxt = last ? DRAIN : LOAD;
      DRAIN: state_nxt = READY;
`ifdef WEIGHT_LOADER_AUTO_COMMIT_EN
      READY: state_nxt = COMMIT;
`else
      READY: state_nxt = bus.commit ? COMMIT : READY;
`endif
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign bus.buf_rd_en = state == LOAD;
  assign bus.buf_rd_addr = state == LOAD ? base + BUFFER_ADDR_WIDTH'(cnt) : '0;
  assign bus.prepare_weight = valid;
  assign {bus.load_weight_data_d_0, bus.load_weight_data_c_0, bus.load_weight_data_b_0, bus.load_weight_data_a_0} =
    (valid && !bank) ? bus.buf_rd_data : '0;
  assign {bus.load_weight_data_d_1, bus.load_weight_data_c_1, bus.load_weight_data_b_1, bus.load_weight_data_a_1} =
    (valid && bank) ? bus.buf_rd_data : '0;
  assign bus.busy = state != IDLE;
  assign bus.weights_ready = state == READY;
  assign bus.set_weight = state == COMMIT;
  assign bus.done = state == COMMIT;
endmodule
